// File: rtl/sync_memory_pkg.sv
// Shared types and default widths for the sync_memory block.
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 7;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_memory_if.sv
// Request/response/clear bus of the sync_memory block.
interface sync_memory_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              clear_req;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, clear_req,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, clear_req,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/sync_memory_array.sv
// Storage: one synchronous write port, one synchronous read port, no reset.
module sync_memory_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_memory.sv
// Single-port request/response memory with a self-clearing CLEAR sequence
// that runs after reset and on clear_req.
module sync_memory
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  sync_memory_if.slave  bus
);

  localparam int              DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;

  logic              accept_p0;
  logic              rd_p0;
  logic              wr_p0;
  logic [ADDR_W-1:0] waddr_p0;
  logic [DATA_W-1:0] wdata_p0;

  assign bus.req_ready = (state == IDLE) && !bus.clear_req && (!vld_p1 || bus.rsp_ready);
  assign accept_p0     = bus.req_valid && bus.req_ready;
  assign rd_p0         = accept_p0 && !bus.req_we;

  // CLEAR owns the write port; otherwise accepted writes use it.
  assign wr_p0    = (state == CLEAR) || (accept_p0 && bus.req_we);
  assign waddr_p0 = (state == CLEAR) ? clr_cnt : bus.req_addr;
  assign wdata_p0 = (state == CLEAR) ? '0 : bus.req_wdata;

  sync_memory_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_p0),
    .waddr (waddr_p0),
    .wdata (wdata_p0),
    .re    (rd_p0),
    .raddr (bus.req_addr),
    .rdata (rdata_p1)
  );

  // ---- stage p1: response register and FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      vld_p1  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (bus.clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= CLEAR;
      endcase

      if (rd_p0)              vld_p1 <= 1'b1;
      else if (bus.rsp_ready) vld_p1 <= 1'b0;
    end
  end

  // The array read register only loads on an accepted read, so it holds while
  // a response is stalled; gating by valid gives zero data out of reset.
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_rdata = vld_p1 ? rdata_p1 : '0;
  assign bus.busy      = (state == CLEAR);

endmodule

// File: tb/tb_sync_memory.sv
// Directed self-checking bench for sync_memory.
module tb_sync_memory;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sync_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sync_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Counts cycles with busy high (bounded); optionally pulses clear_req at cycle poke.
  task automatic count_busy(input int poke, output int n, output int rdy_seen);
    n = 0;
    rdy_seen = 0;
    while (bus.busy && n < 300) begin
      if (n == poke) bus.clear_req = 1'b1;
      #1;
      if (bus.req_ready) rdy_seen = 1;
      @(posedge clk);
      #1;
      bus.clear_req = 1'b0;
      n++;
    end
  endtask

  initial begin
    int n;
    int rdy;
    logic [DATA_W-1:0] tbl [4];
    tbl[0] = 16'hA0A0; tbl[1] = 16'hB1B1; tbl[2] = 16'hC2C2; tbl[3] = 16'hD3D3;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.clear_req = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy",  32'(bus.busy), 32'd1);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_vld",   32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);

    // Initial CLEAR
    rst_n = 1'b1;
    count_busy(-1, n, rdy);
    chk("init_clear_cycles", 32'(n), 32'd128);
    chk("init_ready_in_clear", 32'(rdy), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ready", 32'(bus.req_ready), 32'd1);

    do_read(7'd5);
    chk("rd5_vld",   32'(bus.rsp_valid), 32'd1);
    chk("rd5_rdata", 32'(bus.rsp_rdata), 32'h0000);
    tick();
    chk("rd5_drain", 32'(bus.rsp_valid), 32'd0);

    // Write then read same address next cycle
    do_write(7'h12, 16'hBEEF);
    chk("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    do_read(7'h12);
    chk("raw_vld",   32'(bus.rsp_valid), 32'd1);
    chk("raw_rdata", 32'(bus.rsp_rdata), 32'hBEEF);
    tick();

    // Back-pressure hold
    bus.rsp_ready = 1'b0;
    do_read(7'h12);
    bus.req_valid = 1'b1;
    bus.req_addr  = 7'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
      tick();
      chk("hold_vld",   32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", 32'(bus.rsp_rdata), 32'hBEEF);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("release_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("release_drop", 32'(bus.rsp_valid), 32'd0);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) do_write(ADDR_W'(i), tbl[i]);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr = ADDR_W'(i);
      tick();
      chk("b2b_vld",   32'(bus.rsp_valid), 32'd1);
      chk("b2b_rdata", 32'(bus.rsp_rdata), 32'(tbl[i]));
    end
    bus.req_valid = 1'b0;
    tick();
    chk("b2b_end", 32'(bus.rsp_valid), 32'd0);

    // clear_req sequence, with an ignored re-request mid-CLEAR
    do_write(7'h7F, 16'h1234);
    do_read(7'h7F);
    chk("pre_clr_rdata", 32'(bus.rsp_rdata), 32'h1234);
    tick();
    bus.clear_req = 1'b1;
    #1;
    chk("clr_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.clear_req = 1'b0;
    chk("clr_busy", 32'(bus.busy), 32'd1);
    count_busy(10, n, rdy);
    chk("clr_cycles", 32'(n), 32'd128);
    chk("clr_ready_in_clear", 32'(rdy), 32'd0);
    do_read(7'h7F);
    chk("clr_rd7f", 32'(bus.rsp_rdata), 32'h0000);
    do_read(7'h12);
    chk("clr_rd12", 32'(bus.rsp_rdata), 32'h0000);
    tick();

    // Pending response across CLEAR, then reset at cycle 40
    do_write(7'h7F, 16'h4321);
    do_write(7'h03, 16'h5A5A);
    bus.rsp_ready = 1'b0;
    do_read(7'h03);
    chk("pend_rdata", 32'(bus.rsp_rdata), 32'h5A5A);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (40) tick();
    chk("pend_busy",  32'(bus.busy), 32'd1);
    chk("pend_vld",   32'(bus.rsp_valid), 32'd1);
    chk("pend_rdata_held", 32'(bus.rsp_rdata), 32'h5A5A);
    rst_n = 1'b0;
    #1;
    chk("arst_vld",   32'(bus.rsp_valid), 32'd0);
    chk("arst_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("arst_busy",  32'(bus.busy), 32'd1);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    count_busy(-1, n, rdy);
    chk("restart_cycles", 32'(n), 32'd128);
    chk("restart_ready", 32'(rdy), 32'd0);
    do_read(7'h7F);
    chk("restart_rd_vld",  32'(bus.rsp_valid), 32'd1);
    chk("restart_rd7f",    32'(bus.rsp_rdata), 32'h0000);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
